// File: rtl/pc_gen_ras.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_gen_ras : fetch PC generator with trap/redirect/RAS next-PC selection |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module pc_gen_ras #(
  parameter int              PC_W      = 20,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pc_write,
  input  logic                           trap_valid,
  input  logic [PC_W-1:0]                trap_pc,
  input  logic                           redirect_valid,
  input  logic [PC_W-1:0]                redirect_pc,
  input  logic                           call_push,
  input  logic                           ret_pop,
  output logic [PC_W-1:0]                IF_PC,
  output logic                           if_valid,
  output logic                           redirected,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int              CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam int              PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PC_W-1:0] INC_PC  = PC_W'(INC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             valid_q;
  logic             redirected_q, redirected_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PC_W-1:0]  ras_d [RAS_DEPTH];

  logic [PC_W-1:0]  pc_inc;
  logic [PTR_W-1:0] top_inc;
  logic             do_pop;

  always_comb begin
    pc_inc       = pc_q + INC_PC;
    top_inc      = top_q + PTR_W'(1);
    pc_d         = pc_q;
    redirected_d = 1'b0;
    count_d      = count_q;
    top_d        = top_q;
    ras_d        = ras_q;
    do_pop       = 1'b0;

    if (trap_valid) begin
      pc_d         = trap_pc;
      redirected_d = 1'b1;
      count_d      = '0;
      top_d        = '0;
    end else if (redirect_valid) begin
      pc_d         = redirect_pc;
      redirected_d = 1'b1;
    end else if (pc_write) begin
      do_pop = ret_pop && (count_q != '0);
      pc_d   = do_pop ? ras_q[top_q] : pc_inc;
      // Call+return together: swap the top entry in place, depth unchanged.
      if (do_pop && call_push) begin
        ras_d[top_q] = pc_inc;
      end else if (do_pop) begin
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end else if (call_push) begin
        // Circular buffer: when full the oldest slot is the one overwritten.
        top_d          = top_inc;
        ras_d[top_inc] = pc_inc;
        count_d        = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      redirected_q <= 1'b0;
      count_q      <= '0;
      top_q        <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= 1'b1;
      redirected_q <= redirected_d;
      count_q      <= count_d;
      top_q        <= top_d;
      ras_q        <= ras_d;
    end
  end

  assign IF_PC      = pc_q;
  assign if_valid   = valid_q;
  assign redirected = redirected_q;
  assign ras_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_ras.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_gen_ras : self-checking bench for pc_gen_ras                       |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_pc_gen_ras;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        trap_valid = 1'b0;
  logic [19:0] trap_pc = '0;
  logic        redirect_valid = 1'b0;
  logic [19:0] redirect_pc = '0;
  logic        call_push = 1'b0;
  logic        ret_pop = 1'b0;
  logic [19:0] IF_PC;
  logic        if_valid;
  logic        redirected;
  logic [2:0]  ras_count;

  int tests = 0;
  int fails = 0;

  // Reference model: PC plus a plain queue of return addresses (newest at back).
  logic [19:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic        m_red = 1'b0;
  logic [19:0] m_ras[$];

  pc_gen_ras #(.PC_W(20), .RESET_PC(20'h0), .INC(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .call_push(call_push), .ret_pop(ret_pop),
    .IF_PC(IF_PC), .if_valid(if_valid), .redirected(redirected), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [19:0] seq;
    seq     = m_pc + 20'd4;
    m_valid = 1'b1;
    if (trap_valid) begin
      m_pc = trap_pc; m_red = 1'b1; m_ras.delete();
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_red = 1'b1;
    end else if (!pc_write) begin
      m_red = 1'b0;
    end else begin
      m_red = 1'b0;
      if (ret_pop && m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = seq;
      if (call_push) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
  endtask

  // Drive one cycle of inputs, take the edge, update the model, settle.
  task automatic step(input logic pw, input logic tv, input logic [19:0] tpc,
                      input logic rv, input logic [19:0] rpc,
                      input logic cp, input logic rp);
    pc_write = pw; trap_valid = tv; trap_pc = tpc;
    redirect_valid = rv; redirect_pc = rpc; call_push = cp; ret_pop = rp;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 1, 20'h00123, 0, 0);
    tests++; if (IF_PC !== 20'h00123) begin fails++; $display("FAIL rst_pre IF_PC got %h exp %h", IF_PC, 20'h00123); end
    #2 reset_n = 1'b0;
    m_pc = '0; m_valid = 1'b0; m_red = 1'b0; m_ras.delete();
    #1;
    tests++; if (IF_PC !== 20'h0) begin fails++; $display("FAIL rst_async IF_PC got %h exp %h", IF_PC, 20'h0); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    tests++; if (ras_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", ras_count); end
    #1 reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (IF_PC !== 20'h4) begin fails++; $display("FAIL rst_seq1 got %h exp %h", IF_PC, 20'h4); end
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL rst_valid1 got %b exp 1", if_valid); end
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (IF_PC !== 20'h8) begin fails++; $display("FAIL rst_seq2 got %h exp %h", IF_PC, 20'h8); end
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (IF_PC !== 20'hC) begin fails++; $display("FAIL rst_seq3 got %h exp %h", IF_PC, 20'hC); end
  endtask

  task automatic test_stall_flush();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    tests++; if (IF_PC !== 20'hC) begin fails++; $display("FAIL stall_hold got %h exp %h", IF_PC, 20'hC); end
    tests++; if (ras_count !== 3'd0) begin fails++; $display("FAIL stall_ras got %0d exp 0", ras_count); end
    step(0, 0, 0, 1, 20'h00200, 0, 0);
    tests++; if (IF_PC !== 20'h00200) begin fails++; $display("FAIL flush_pc got %h exp %h", IF_PC, 20'h00200); end
    tests++; if (redirected !== 1'b1) begin fails++; $display("FAIL flush_red got %b exp 1", redirected); end
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (redirected !== 1'b0) begin fails++; $display("FAIL flush_red_drop got %b exp 0", redirected); end
    tests++; if (IF_PC !== 20'h00204) begin fails++; $display("FAIL flush_next got %h exp %h", IF_PC, 20'h00204); end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, 0, 1, 0);
    tests++; if (ras_count !== 3'd1) begin fails++; $display("FAIL prio_pre_count got %0d exp 1", ras_count); end
    step(1, 1, 20'h00400, 1, 20'h00800, 1, 1);
    tests++; if (IF_PC !== 20'h00400) begin fails++; $display("FAIL prio_pc got %h exp %h", IF_PC, 20'h00400); end
    tests++; if (ras_count !== 3'd0) begin fails++; $display("FAIL prio_count got %0d exp 0", ras_count); end
    tests++; if (redirected !== 1'b1) begin fails++; $display("FAIL prio_red got %b exp 1", redirected); end
  endtask

  task automatic test_ras();
    step(1, 1, 20'h010, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 20'h020, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    tests++; if (ras_count !== 3'd2) begin fails++; $display("FAIL ras_count2 got %0d exp 2", ras_count); end
    step(1, 0, 0, 0, 0, 0, 1);
    tests++; if (IF_PC !== 20'h024) begin fails++; $display("FAIL ras_pop1 got %h exp %h", IF_PC, 20'h024); end
    step(1, 0, 0, 0, 0, 0, 1);
    tests++; if (IF_PC !== 20'h014) begin fails++; $display("FAIL ras_pop2 got %h exp %h", IF_PC, 20'h014); end
    step(1, 0, 0, 0, 0, 0, 1);
    tests++; if (IF_PC !== 20'h018) begin fails++; $display("FAIL ras_pop_empty got %h exp %h", IF_PC, 20'h018); end
    tests++; if (ras_count !== 3'd0) begin fails++; $display("FAIL ras_empty_count got %0d exp 0", ras_count); end
  endtask

  task automatic test_overflow();
    logic [19:0] exp_pc;
    step(1, 1, 20'h100, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) step(1, 0, 0, 1, 20'(i * 20'h100), 0, 0);
      step(1, 0, 0, 0, 0, 1, 0);
    end
    tests++; if (ras_count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", ras_count); end
    for (int i = 5; i >= 2; i--) begin
      step(1, 0, 0, 0, 0, 0, 1);
      exp_pc = 20'(i * 20'h100 + 4);
      tests++; if (IF_PC !== exp_pc) begin fails++; $display("FAIL ovf_pop%0d got %h exp %h", i, IF_PC, exp_pc); end
    end
    step(1, 0, 0, 1, 20'h600, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 20'h700, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    tests++; if (IF_PC !== 20'h604) begin fails++; $display("FAIL pushpop_pc got %h exp %h", IF_PC, 20'h604); end
    tests++; if (ras_count !== 3'd1) begin fails++; $display("FAIL pushpop_count got %0d exp 1", ras_count); end
    step(1, 0, 0, 0, 0, 0, 1);
    tests++; if (IF_PC !== 20'h704) begin fails++; $display("FAIL pushpop_new_top got %h exp %h", IF_PC, 20'h704); end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 1, 20'hFFFFC, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    tests++; if (IF_PC !== 20'h00000) begin fails++; $display("FAIL wrap_pc got %h exp %h", IF_PC, 20'h0); end
    tests++; if (redirected !== 1'b0) begin fails++; $display("FAIL wrap_red got %b exp 0", redirected); end
  endtask

  task automatic test_random();
    logic tv, rv;
    for (int n = 0; n < 400; n++) begin
      tv = ($urandom_range(0, 29) == 0);
      rv = ($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 4) != 0), tv, 20'($urandom) & 20'hFFFFC, rv,
           20'($urandom) & 20'hFFFFC, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      tests++; if (IF_PC !== m_pc) begin fails++; $display("FAIL rnd_pc cyc %0d got %h exp %h", n, IF_PC, m_pc); end
      tests++; if (ras_count !== 3'(m_ras.size())) begin fails++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, ras_count, m_ras.size()); end
      tests++; if (redirected !== m_red) begin fails++; $display("FAIL rnd_red cyc %0d got %b exp %b", n, redirected, m_red); end
      tests++; if (if_valid !== m_valid) begin fails++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, if_valid, m_valid); end
    end
  endtask

  initial begin
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_stall_flush();
    test_priority();
    test_ras();
    test_overflow();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
